timer_tick_scheduler: RTL
=========================

Name: timer_tick_scheduler

Overview:
- Avalon-MM master that configures and services one 16-bit-slave interval timer (6 halfword registers: status, control, period_l, period_h, snap_l, snap_h).
- Programs the period, starts the timer in continuous IRQ mode, acknowledges each timeout and fans the base tick out to N channels, each with its own divider.
- Sits between the control/CSR logic and the timer, replacing a CPU interrupt handler for periodic events.

Parameters:
- N_CH, 4, number of tick channels (1..8)
- DIV_W, 8, width of each channel divider
- MIN_PERIOD, 8, smallest period value written to the timer; smaller requests are clamped

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cfg_start  in  1  one-cycle pulse: program the timer and start it; ignored unless in IDLE
- cfg_stop  in  1  one-cycle pulse: stop the timer, return to IDLE
- cfg_period  in  32  timer period value; base tick interval is cfg_period+1 clocks; sampled on an accepted cfg_start
- ch_en  in  N_CH  per-channel enable
- ch_div  in  N_CH*DIV_W  per-channel divider, channel i at bits [i*DIV_W +: DIV_W]; 0 is treated as 1
- tmr_address  out  3  timer register index
- tmr_chipselect  out  1  timer select
- tmr_write_n  out  1  active-low write
- tmr_writedata  out  16  timer write data
- tmr_readdata  in  16  timer read data, registered in the timer (valid one cycle after the address)
- tmr_irq  in  1  timer interrupt (level)
- busy  out  1  high in every state except IDLE
- tick  out  N_CH  one-cycle tick pulses
- base_count  out  16  number of serviced timeouts since start; wraps
- spurious  out  1  sticky; set when the IRQ is high but status TO=0; cleared by cfg_start

Behaviour:
- Reset (asynchronous) values: state IDLE, tmr_chipselect=0, tmr_write_n=1, tmr_address=0, tmr_writedata=0, tick=0, base_count=0, spurious=0, channel counters=0, busy=0.
- One bus access per cycle, no waitrequest. Write = chipselect=1, write_n=0 for exactly one cycle. Read = chipselect=1, write_n=1, address held for 2 cycles; readdata is sampled in the second cycle.
- FSM states and actions:
  - IDLE: on cfg_start, latch P = max(cfg_period, MIN_PERIOD), clear spurious, base_count and channel counters, go to WR_PL.
  - WR_PL: write address 2 = P[15:0].
  - WR_PH: write address 3 = P[31:16].
  - WR_CTRL: write address 1 = 16'h0007 (ITO, CONT, START), go to RUN.
  - RUN: bus idle. cfg_stop goes to WR_STOP. Otherwise tmr_irq=1 goes to RD_ST.
  - RD_ST: read address 0, go to RD_WAIT.
  - RD_WAIT: read address 0, sample readdata[0].
    - If TO=1, go to CLR_ST.
    - Otherwise set spurious and go to RUN.
  - CLR_ST: write address 0 = 0 (clears TO), go to DISPATCH.
  - DISPATCH: base_count += 1. For each enabled channel, if cnt_i+1 >= div_i, set cnt_i=0 and pulse tick[i]; otherwise cnt_i += 1. Go to RUN.
  - WR_STOP: write address 1 = 16'h0008 (STOP), go to IDLE.
- Latency: tmr_irq is first seen high in RUN at cycle t. RD_ST runs at t+1, RD_WAIT at t+2, CLR_ST at t+3, tick at t+4, and the FSM is back in RUN at t+5.
- cfg_stop is accepted in any non-IDLE state. It is latched as pending and acted on at the next RUN entry or in RUN; a timeout in progress finishes its DISPATCH first. cfg_stop has priority over tmr_irq in RUN.
- cfg_start while busy: ignored. cfg_start and cfg_stop together in IDLE: start wins, and the stop is discarded.
- A disabled channel holds its counter and never ticks. ch_div may change at any time; it takes effect at the next DISPATCH.
- The clamp to MIN_PERIOD guarantees the 5-cycle service completes before the next timeout.
- Reset mid-operation: immediate return to IDLE with reset values. The timer shares reset_n, so no stop write is needed.

Decomposition:
- Shared package: timer register indices (STATUS=0, CONTROL=1, PERIODL=2, PERIODH=3, SNAPL=4, SNAPH=5), control bit constants (ITO=0, CONT=1, START=2, STOP=3), and the FSM state enum.
- One sub-module, tick_divider_channel: per-channel counter, enable and divider compare, instantiated N_CH times with a generate loop.

Test Plan:
- Reset and start with cfg_period=100 -> three writes on consecutive cycles: addr2=0x0064, addr3=0x0000, addr1=0x0007; busy=1 from the cycle after start.
- Timer model asserts tmr_irq with status readdata=0x0003 -> reads addr0 for 2 cycles, write addr0=0 at t+3, base_count increments and tick pulses at t+4.
- ch_div={0,1,3,5}, all enabled, 30 timeouts -> ch0 and ch1 tick 30 times, ch2 10 times, ch3 6 times.
- tmr_irq high with status readdata=0x0002 -> spurious=1, no clear write, no tick, back to RUN.
- cfg_stop on the same cycle as tmr_irq in RUN -> single write addr1=0x0008, then IDLE with busy=0. Separately, cfg_period=3 -> addr2 is written as 0x0008.
- reset_n pulsed low during CLR_ST -> all outputs immediately at reset values; a later cfg_start reprograms normally.

Source files
------------

// File: rtl/timer_tick_scheduler_pkg.sv
// Shared definitions for the timer tick scheduler: timer register map, control
// word bits, FSM state encoding and the period clamp helper.
package timer_tick_scheduler_pkg;

    localparam int unsigned TMR_ADDR_W = 3;
    localparam int unsigned TMR_DATA_W = 16;

    // Interval timer halfword register indices
    localparam logic [TMR_ADDR_W-1:0] REG_STATUS  = 3'd0;
    localparam logic [TMR_ADDR_W-1:0] REG_CONTROL = 3'd1;
    localparam logic [TMR_ADDR_W-1:0] REG_PERIODL = 3'd2;
    localparam logic [TMR_ADDR_W-1:0] REG_PERIODH = 3'd3;
    localparam logic [TMR_ADDR_W-1:0] REG_SNAPL   = 3'd4;
    localparam logic [TMR_ADDR_W-1:0] REG_SNAPH   = 3'd5;

    // Control register bit positions
    localparam int unsigned CTRL_ITO   = 0;
    localparam int unsigned CTRL_CONT  = 1;
    localparam int unsigned CTRL_START = 2;
    localparam int unsigned CTRL_STOP  = 3;

    localparam logic [TMR_DATA_W-1:0] CTRL_RUN_WORD =
        16'((1 << CTRL_ITO) | (1 << CTRL_CONT) | (1 << CTRL_START));
    localparam logic [TMR_DATA_W-1:0] CTRL_STOP_WORD = 16'(1 << CTRL_STOP);

    typedef enum logic [3:0] {
        StIdle,
        StWrPl,
        StWrPh,
        StWrCtrl,
        StRun,
        StRdSt,
        StRdWait,
        StClrSt,
        StDispatch,
        StWrStop
    } state_e;

    // Periods below min_p would let the next timeout arrive mid-service.
    function automatic logic [31:0] clamp_period(input logic [31:0] p, input logic [31:0] min_p);
        return (p < min_p) ? min_p : p;
    endfunction

endpackage

// File: rtl/timer_tick_scheduler_if.sv
// Avalon-MM bus between the scheduler (master) and the interval timer (slave).
//   address/chipselect/write_n/writedata : master -> timer
//   readdata (registered in timer), irq  : timer -> master
interface timer_tick_scheduler_if;
    import timer_tick_scheduler_pkg::*;

    logic [TMR_ADDR_W-1:0] address;
    logic                  chipselect;
    logic                  write_n;
    logic [TMR_DATA_W-1:0] writedata;
    logic [TMR_DATA_W-1:0] readdata;
    logic                  irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );

endinterface

// File: rtl/timer_tick_scheduler_tick_divider_channel.sv
// One tick channel: divides serviced base ticks by div (0 treated as 1).
//   clk, reset_n : clock, async active-low reset
//   clr          : zero the counter (new start)
//   step         : a base tick is being dispatched this cycle
//   en           : channel enable; disabled channels hold their count
//   div          : divider value, sampled on step
//   tick         : registered one-cycle pulse, aligned with the dispatch cycle
module tick_divider_channel #(
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             step,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W:0]   cnt_inc;
    logic [DIV_W:0]   div_eff;
    logic             hit;

    // One extra bit so cnt+1 never wraps before the compare.
    assign cnt_inc = {1'b0, cnt} + {{DIV_W{1'b0}}, 1'b1};
    assign div_eff = (div == '0) ? {{DIV_W{1'b0}}, 1'b1} : {1'b0, div};
    assign hit     = (cnt_inc >= div_eff);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (clr) begin
                cnt <= '0;
            end else if (step && en) begin
                if (hit) begin
                    cnt  <= '0;
                    tick <= 1'b1;
                end else begin
                    cnt <= cnt_inc[DIV_W-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/timer_tick_scheduler.sv
// Programs an interval timer for continuous IRQ mode, services each timeout
// (status read, TO clear) and fans the base tick out to N_CH divided channels.
//   clk, reset_n         : clock, async active-low reset (shared with the timer)
//   cfg_start, cfg_stop  : start/stop pulses; cfg_period sampled on accepted start
//   ch_en, ch_div        : per-channel enable and divider
//   tmr                  : Avalon-MM master port to the timer
//   busy                 : not idle
//   tick                 : per-channel one-cycle tick pulses
//   base_count           : serviced timeouts since start (wraps)
//   spurious             : sticky, IRQ seen with TO=0; cleared by start
module timer_tick_scheduler
    import timer_tick_scheduler_pkg::*;
#(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned DIV_W      = 8,
    parameter int unsigned MIN_PERIOD = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    cfg_start,
    input  logic                    cfg_stop,
    input  logic [31:0]             cfg_period,
    input  logic [N_CH-1:0]         ch_en,
    input  logic [N_CH*DIV_W-1:0]   ch_div,
    timer_tick_scheduler_if.master  tmr,
    output logic                    busy,
    output logic [N_CH-1:0]         tick,
    output logic [15:0]             base_count,
    output logic                    spurious
);

    state_e      state;
    logic        stop_pend;
    logic [15:0] period_hi;
    logic [31:0] period_clamped;
    logic        go_stop;
    logic        ch_clr;
    logic        ch_step;
    logic        unused_rd;

    assign period_clamped = clamp_period(cfg_period, 32'(MIN_PERIOD));
    assign go_stop        = stop_pend | cfg_stop;
    assign ch_clr         = (state == StIdle) && cfg_start;
    // Channels update on the CLR_ST edge so their ticks land in the DISPATCH cycle.
    assign ch_step        = (state == StClrSt);
    assign busy           = (state != StIdle);
    assign unused_rd      = ^tmr.readdata[15:1];

    // Bus outputs are registered: each transition loads the access of the state entered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= StIdle;
            stop_pend      <= 1'b0;
            period_hi      <= '0;
            base_count     <= '0;
            spurious       <= 1'b0;
            tmr.address    <= '0;
            tmr.chipselect <= 1'b0;
            tmr.write_n    <= 1'b1;
            tmr.writedata  <= '0;
        end else begin
            tmr.chipselect <= 1'b0;
            tmr.write_n    <= 1'b1;
            if (cfg_stop && (state != StIdle)) begin
                stop_pend <= 1'b1;
            end

            unique case (state)
                StIdle: begin
                    // A stop arriving with (or without) a start in IDLE is discarded.
                    stop_pend <= 1'b0;
                    if (cfg_start) begin
                        state          <= StWrPl;
                        period_hi      <= period_clamped[31:16];
                        spurious       <= 1'b0;
                        base_count     <= '0;
                        tmr.chipselect <= 1'b1;
                        tmr.write_n    <= 1'b0;
                        tmr.address    <= REG_PERIODL;
                        tmr.writedata  <= period_clamped[15:0];
                    end
                end
                StWrPl: begin
                    state          <= StWrPh;
                    tmr.chipselect <= 1'b1;
                    tmr.write_n    <= 1'b0;
                    tmr.address    <= REG_PERIODH;
                    tmr.writedata  <= period_hi;
                end
                StWrPh: begin
                    state          <= StWrCtrl;
                    tmr.chipselect <= 1'b1;
                    tmr.write_n    <= 1'b0;
                    tmr.address    <= REG_CONTROL;
                    tmr.writedata  <= CTRL_RUN_WORD;
                end
                StWrCtrl, StDispatch, StRun: begin
                    if (go_stop) begin
                        state          <= StWrStop;
                        stop_pend      <= 1'b0;
                        tmr.chipselect <= 1'b1;
                        tmr.write_n    <= 1'b0;
                        tmr.address    <= REG_CONTROL;
                        tmr.writedata  <= CTRL_STOP_WORD;
                    end else if ((state == StRun) && tmr.irq) begin
                        state          <= StRdSt;
                        tmr.chipselect <= 1'b1;
                        tmr.address    <= REG_STATUS;
                    end else begin
                        state <= StRun;
                    end
                end
                StRdSt: begin
                    // Hold the read a second cycle; readdata is valid then.
                    state          <= StRdWait;
                    tmr.chipselect <= 1'b1;
                end
                StRdWait: begin
                    if (tmr.readdata[0]) begin
                        state          <= StClrSt;
                        tmr.chipselect <= 1'b1;
                        tmr.write_n    <= 1'b0;
                        tmr.address    <= REG_STATUS;
                        tmr.writedata  <= '0;
                    end else begin
                        spurious <= 1'b1;
                        if (go_stop) begin
                            state          <= StWrStop;
                            stop_pend      <= 1'b0;
                            tmr.chipselect <= 1'b1;
                            tmr.write_n    <= 1'b0;
                            tmr.address    <= REG_CONTROL;
                            tmr.writedata  <= CTRL_STOP_WORD;
                        end else begin
                            state <= StRun;
                        end
                    end
                end
                StClrSt: begin
                    state      <= StDispatch;
                    base_count <= base_count + 16'd1;
                end
                StWrStop: begin
                    state     <= StIdle;
                    stop_pend <= 1'b0;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        tick_divider_channel #(
            .DIV_W(DIV_W)
        ) u_ch (
            .clk    (clk),
            .reset_n(reset_n),
            .clr    (ch_clr),
            .step   (ch_step),
            .en     (ch_en[i]),
            .div    (ch_div[i*DIV_W +: DIV_W]),
            .tick   (tick[i])
        );
    end

endmodule
